// File: rtl/uart_cmd_if.sv
// Byte-stream command bus between the UART receiver side and uart_cmd_ctrl.
// The master drives received bytes and the busy stall; the slave issues requests.
interface uart_cmd_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic             i_data_valid;
    logic             i_busy;
    logic             o_wr_en;
    logic             o_rd_en;
    logic [WIDTH-1:0] o_addr;
    logic [WIDTH-1:0] o_wdata;
    logic             o_frame_ok;
    logic             o_frame_err;
    logic             o_overrun;

    modport master (
        output i_data, i_data_valid, i_busy,
        input  o_wr_en, o_rd_en, o_addr, o_wdata,
        input  o_frame_ok, o_frame_err, o_overrun
    );

    modport slave (
        input  i_data, i_data_valid, i_busy,
        output o_wr_en, o_rd_en, o_addr, o_wdata,
        output o_frame_ok, o_frame_err, o_overrun
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/CMD/ADDR/DATA[/CSUM] packets into single-beat register requests.
// UART_CMD_CHECKSUM_EN adds the trailing XOR checksum byte and its check.
module uart_cmd_ctrl #(
    parameter int               WIDTH     = 8,
    parameter int               TIMEOUT   = 100000,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] CMD_WR    = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] CMD_RD    = WIDTH'(8'h02)
) (
    input logic       clk,
    input logic       i_reset,
    uart_cmd_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_ISSUE
    } state_t;

    state_t           state_q, state_d;
    logic             cmd_wr_q, cmd_wr_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ok_d, err_d, ovr_d;

    logic             wr_q, rd_q, ok_q, err_q, ovr_q;
    logic [WIDTH-1:0] oaddr_q, owdata_q;
    logic             issue_d;

    always_comb begin
        state_d  = state_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        csum_d   = csum_q;
        cnt_d    = cnt_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                csum_d = '0;
                if (bus.i_data_valid && bus.i_data == SYNC_BYTE)
                    state_d = S_CMD;
            end
            S_ISSUE: begin
                // Bytes cannot be buffered while the request is pending.
                ovr_d = bus.i_data_valid;
                if (!bus.i_busy)
                    state_d = S_IDLE;
            end
            default: begin
                if (bus.i_data_valid) begin
                    cnt_d  = '0;
                    csum_d = csum_q ^ bus.i_data;
                    case (state_q)
                        S_CMD: begin
                            if (bus.i_data == CMD_WR ||
                                bus.i_data == CMD_RD) begin
                                cmd_wr_d = (bus.i_data == CMD_WR);
                                state_d  = S_ADDR;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        S_ADDR: begin
                            addr_d  = bus.i_data;
                            state_d = S_DATA;
                        end
                        S_DATA: begin
                            data_d = bus.i_data;
`ifdef UART_CMD_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_ISSUE;
                            ok_d    = 1'b1;
`endif
                        end
`ifdef UART_CMD_CHECKSUM_EN
                        S_CSUM: begin
                            if (bus.i_data == csum_q) begin
                                state_d = S_ISSUE;
                                ok_d    = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
`endif
                        default: state_d = S_IDLE;
                    endcase
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign issue_d = (state_d == S_ISSUE);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            csum_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            oaddr_q  <= '0;
            owdata_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
            wr_q     <= issue_d && cmd_wr_d;
            rd_q     <= issue_d && !cmd_wr_d;
            oaddr_q  <= issue_d ? addr_d : '0;
            owdata_q <= (issue_d && cmd_wr_d) ? data_d : '0;
            ok_q     <= ok_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.o_wr_en     = wr_q;
    assign bus.o_rd_en     = rd_q;
    assign bus.o_addr      = oaddr_q;
    assign bus.o_wdata     = owdata_q;
    assign bus.o_frame_ok  = ok_q;
    assign bus.o_frame_err = err_q;
    assign bus.o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: frame-level expectations are queued
// by the stimulus tasks and consumed by an independent output monitor.
module tb_uart_cmd_ctrl;
    localparam int TO = 16;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] WR = 8'h01;
    localparam logic [7:0] RD = 8'h02;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        int       at;
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        int       len;
    } req_t;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    int   cyc = 0;
    int   last_edge = 0;
    int   total = 0;
    int   bad = 0;

    req_t req_q[$];
    int   err_q[$];
    int   ovr_q[$];

    uart_cmd_if #(.WIDTH(8)) bus ();

    uart_cmd_ctrl #(
        .WIDTH(8),
        .TIMEOUT(TO),
        .SYNC_BYTE(SYNC),
        .CMD_WR(WR),
        .CMD_RD(RD)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an event.
    req_t cur;
    bit   act = 1'b0;
    int   hold = 0;
    always @(negedge clk) begin
        if (bus.o_frame_err) begin
            chk("err_with_ok", int'(bus.o_frame_ok), 0);
            chk("err_pending", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) chk("err_cycle", cyc, err_q.pop_front());
        end
        if (bus.o_overrun) begin
            chk("ovr_pending", int'(ovr_q.size() > 0), 1);
            if (ovr_q.size() > 0) chk("ovr_cycle", cyc, ovr_q.pop_front());
        end
        if (bus.o_frame_ok) begin
            chk("ok_pending", int'(req_q.size() > 0), 1);
            if (req_q.size() > 0) begin
                cur = req_q.pop_front();
                chk("ok_cycle", cyc, cur.at);
                act = 1'b1;
                hold = 0;
            end
        end else if (!act && (bus.o_wr_en || bus.o_rd_en)) begin
            chk("req_unexpected", int'(bus.o_wr_en | bus.o_rd_en), 0);
        end
        if (act) begin
            if (bus.o_wr_en || bus.o_rd_en) begin
                hold++;
                chk("req_wr", int'(bus.o_wr_en), int'(cur.wr));
                chk("req_rd", int'(bus.o_rd_en), int'(!cur.wr));
                chk("req_addr", int'(bus.o_addr), int'(cur.addr));
                chk("req_wdata", int'(bus.o_wdata), int'(cur.wdata));
            end else begin
                chk("req_len", hold, cur.len);
                act = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_data_valid = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.i_data = b;
        bus.i_data_valid = 1'b1;
        last_edge = cyc + 1;
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] b;
        do b = 8'($urandom); while (b == SYNC);
        return b;
    endfunction

    function automatic logic [7:0] rcmd();
        return ($urandom_range(1, 0) == 1) ? WR : RD;
    endfunction

    function automatic int gap(input int gfix);
        if (gfix >= 0) return gfix;
        if ($urandom_range(3, 0) == 0) return TO - 1;
        return $urandom_range(3, 0);
    endfunction

    // Full frame; the checksum byte is only sent in the checksum build.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] cs,
                              input int gfix, input int busy_n,
                              input int ovr_j, input int rst_j);
        bit ok;
        int e;
        req_t r;
        put(SYNC);
        idle(gap(gfix));
        put(c);
        idle(gap(gfix));
        put(a);
        idle(gap(gfix));
        put(d);
        if (CS) begin
            idle(gap(gfix));
            put(cs);
        end
        ok = !CS || (cs == (c ^ a ^ d));
        e = last_edge;
        if (!ok) begin
            err_q.push_back(e);
            return;
        end
        r.at = e;
        r.wr = (c == WR);
        r.addr = a;
        r.wdata = (c == WR) ? d : 8'h00;
        r.len = (rst_j >= 0) ? rst_j + 1 : busy_n + 1;
        req_q.push_back(r);
        for (int j = 0; j <= busy_n; j++) begin
            @(negedge clk);
            bus.i_data_valid = 1'b0;
            bus.i_busy = (j < busy_n);
            if (j == rst_j) begin
                i_reset = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                bus.i_busy = 1'b0;
                break;
            end
            if (j == ovr_j) begin
                bus.i_data = ($urandom_range(1, 0) == 1) ? SYNC : junk();
                bus.i_data_valid = 1'b1;
                ovr_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic bad_cmd(input logic [7:0] c);
        put(SYNC);
        idle(gap(-1));
        put(c);
        err_q.push_back(last_edge);
    endtask

    task automatic timeout_frame(input int k);
        put(SYNC);
        if (k >= 2) put(rcmd());
        if (k >= 3) put(8'($urandom));
        if (k >= 4) put(8'($urandom));
        err_q.push_back(last_edge + TO);
        idle(TO + 2);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk(nm, int'({bus.o_wr_en, bus.o_rd_en, bus.o_addr, bus.o_wdata,
                      bus.o_frame_ok, bus.o_frame_err, bus.o_overrun}), 0);
    endtask

    task automatic reset_mid(input int k);
        put(SYNC);
        if (k >= 2) put(rcmd());
        if (k >= 3) put(8'($urandom));
        @(negedge clk);
        bus.i_data_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_idle_outputs("reset_mid_outputs");
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, a, d, cs;
        int fl, sel, bn, oj, rj;
        fl = CS ? 5 : 4;
        bus.i_data = 8'h00;
        bus.i_data_valid = 1'b0;
        bus.i_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_outputs");
        i_reset = 1'b0;

        send_frame(WR, 8'h10, 8'h3C, 8'h2D, 0, 0, -1, -1);
        send_frame(RD, 8'h20, 8'h00, 8'h22, 0, 5, -1, -1);
        if (CS) send_frame(WR, 8'h10, 8'h3C, 8'h00, 0, 0, -1, -1);
        send_frame(WR, 8'h11, 8'h5A, 8'h4A, 0, 0, -1, -1);
        bad_cmd(8'h07);
        put(8'h11);
        put(8'h22);
        send_frame(RD, 8'h33, 8'h99, 8'hA8, 0, 1, -1, -1);
        timeout_frame(2);
        send_frame(WR, 8'h44, 8'h12, 8'h57, TO - 1, 0, -1, -1);
        send_frame(RD, 8'h55, 8'h00, 8'h57, 0, 4, 2, -1);
        send_frame(WR, 8'h66, 8'h77, 8'h10, 0, 3, 3, -1);
        reset_mid(2);
        send_frame(WR, 8'h01, 8'hFF, 8'hFF, 0, 0, -1, -1);
        send_frame(RD, 8'h02, 8'h00, 8'h00, 0, 5, -1, 2);
        send_frame(WR, 8'hFE, 8'h80, 8'h7F, 0, 0, -1, -1);

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(2, 0)) put(junk());
            sel = $urandom_range(9, 0);
            c = rcmd();
            a = 8'($urandom);
            d = 8'($urandom);
            cs = c ^ a ^ d;
            if (sel == 6 && CS) cs = cs ^ 8'($urandom_range(255, 1));
            if (sel <= 6) begin
                bn = ($urandom_range(1, 0) == 1) ? $urandom_range(6, 1) : 0;
                rj = (bn > 0 && $urandom_range(9, 0) == 0)
                     ? $urandom_range(bn - 1, 0) : -1;
                oj = (rj < 0 && $urandom_range(2, 0) == 0)
                     ? $urandom_range(bn, 0) : -1;
                send_frame(c, a, d, cs, -1, bn, oj, rj);
            end else if (sel == 7) begin
                do c = 8'($urandom); while (c == WR || c == RD);
                bad_cmd(c);
            end else if (sel == 8) begin
                timeout_frame($urandom_range(fl - 1, 1));
            end else begin
                reset_mid($urandom_range(3, 1));
            end
        end

        idle(TO + 5);
        chk("req_left", req_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        chk("ovr_left", ovr_q.size(), 0);
        chk("req_open", int'(act), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-stream command controller sitting directly downstream of the UART receiver in the test-counter design. It consumes the receiver's data/valid pulse stream, frames fixed-length command packets, validates them, and issues single-beat register read/write requests to the on-chip register target with a busy-stall handshake. Malformed, timed-out or overrun frames are discarded and flagged; the controller always resynchronises on the next sync byte.

## Interface
- WIDTH, 8, byte width; also address and write-data width
- TIMEOUT, 100000, max idle clk cycles between bytes inside a frame (≥2)
- SYNC_BYTE, 8'hA5, frame start marker
- CMD_WR, 8'h01, write command code
- CMD_RD, 8'h02, read command code

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_data  in  WIDTH  received byte, valid only with i_data_valid
- i_data_valid  in  1  single-cycle byte strobe from receiver
- i_busy  in  1  register target stall; request held while high
- o_wr_en  out  1  write request
- o_rd_en  out  1  read request
- o_addr  out  WIDTH  request address
- o_wdata  out  WIDTH  write data (0 for reads)
- o_frame_ok  out  1  one-cycle pulse: valid frame accepted
- o_frame_err  out  1  one-cycle pulse: bad command, bad checksum or timeout
- o_overrun  out  1  one-cycle pulse: byte dropped during ISSUE

## Operation
- Frame: SYNC, CMD, ADDR, DATA, CSUM; CSUM = CMD ^ ADDR ^ DATA. DATA is sent (ignored) for reads.
- States: IDLE, CMD, ADDR, DATA, CSUM, ISSUE. A byte is accepted on the edge where i_data_valid=1.
- IDLE: byte == SYNC_BYTE -> CMD; any other byte ignored, no flag.
- CMD: CMD_WR or CMD_RD -> latch, ADDR; other value -> o_frame_err, IDLE.
- ADDR -> latch, DATA. DATA -> latch, CSUM. CSUM: match -> ISSUE + o_frame_ok; mismatch -> o_frame_err, IDLE.
- ISSUE: o_wr_en (CMD_WR) or o_rd_en (CMD_RD) high with o_addr/o_wdata stable; completes on edge with i_busy=0; next cycle IDLE, request low.
- Bytes arriving in ISSUE are dropped with o_overrun; a SYNC dropped there is not remembered.
- Timeout counter: runs in CMD..CSUM, cleared on every accepted byte and on entry/IDLE; at count TIMEOUT-1 -> IDLE, o_frame_err. Width $clog2(TIMEOUT).
- Checksum accumulator: XOR, cleared in IDLE, WIDTH bits, no carry.

## Timing
- Reset: all outputs 0, state IDLE, counter and accumulator 0; applies mid-frame and mid-ISSUE (request drops next cycle, frame lost, no flag).
- All outputs registered. Final byte on edge N -> o_wr_en/o_rd_en and o_frame_ok high in cycle N+1.
- i_busy=0 in cycle N+1: request is exactly one cycle; otherwise held until first cycle with i_busy=0 inclusive.
- Back-to-back: SYNC accepted earliest the edge after ISSUE completes (IDLE cycle is not required to see a byte... SYNC in ISSUE's last cycle is an overrun).
- Simultaneous byte and timeout expiry: byte wins, counter clears.
- o_frame_err and o_frame_ok never coincide; each at most one cycle per frame.

## Configuration
- UART_CMD_CHECKSUM_EN defined: 5-byte frame, CSUM state and check as above.
- Undefined: CSUM state removed; DATA byte -> ISSUE + o_frame_ok directly (4-byte frame); checksum mismatch error impossible; other errors unchanged.

## Test plan
- Write A5 01 10 3C 2D, i_busy=0 -> o_wr_en one cycle, o_addr=10, o_wdata=3C, o_frame_ok pulse.
- Read A5 02 20 00 22, i_busy high 5 cycles -> o_rd_en held 6 cycles, o_addr=20, o_wdata=00.
- A5 01 10 3C 00 -> o_frame_err pulse, no request; following valid frame accepted normally.
- A5 07 -> o_frame_err after CMD byte; bytes 11 22 before next A5 ignored silently.
- A5 01 then TIMEOUT cycles silence -> o_frame_err at count TIMEOUT-1, IDLE; byte on expiry cycle instead -> accepted, no error.
- Byte during held ISSUE -> o_overrun; i_reset mid-ADDR -> all outputs 0, next A5 frame works.
